// File: rtl/rle_pkg.sv
// Shared types, constants and helpers for the run-length decoder slice.
// Literals and counts share one 7-bit word; the tag bit tells them apart.
package rle_pkg;

  localparam int DATA_W = 7;

  localparam logic [DATA_W-1:0] MIN_CHAR  = 7'd32;
  localparam logic [DATA_W-1:0] DATA_ZERO = 7'd0;
  localparam logic [DATA_W-1:0] DATA_ONE  = 7'd1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HAVE_CNT = 2'd1,
    EMIT     = 2'd2
  } rle_state_e;

  function automatic logic is_legal_char(input logic [DATA_W-1:0] c);
    return (c >= MIN_CHAR);
  endfunction

endpackage

// File: rtl/rle_repeat_counter.sv
// Holds the number of copies still owed after the first one is presented.
// last flags the decrement that retires the final pending copy.
module rle_repeat_counter
  import rle_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_value,
  input  logic              dec,
  output logic              last
);

  logic [DATA_W-1:0] rem_r;

  // Remaining-copies register: load wins over decrement, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_r <= DATA_ZERO;
    end else if (load) begin
      rem_r <= load_value;
    end else if (dec && (rem_r != DATA_ZERO)) begin
      rem_r <= rem_r - DATA_ONE;
    end else begin
      rem_r <= rem_r;
    end
  end

  assign last = dec && (rem_r == DATA_ONE);

endmodule

// File: rtl/rle_decoder.sv
// Expands count/character pairs from the run-length encoder into a
// valid/ready character stream; malformed words raise a one-cycle err.
module rle_decoder
  import rle_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              err
);

  rle_state_e        state_r;
  logic [DATA_W-1:0] cnt_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              err_r;

  logic slot_free_s;
  logic in_ready_s;
  logic accept_s;
  logic handshake_s;
  logic lit_ok_s;
  logic rem_load_s;
  logic rem_dec_s;
  logic rem_last_s;

  assign slot_free_s = !out_valid_r || out_ready;
  assign in_ready_s  = (state_r != EMIT) && slot_free_s;
  assign accept_s    = in_valid && in_ready_s;
  assign handshake_s = out_valid_r && out_ready;
  assign lit_ok_s    = is_legal_char(in_data);

  // The first copy goes out directly, so the counter only tracks cnt-1.
  assign rem_load_s = accept_s && !in_tag && lit_ok_s && (state_r == HAVE_CNT);
  assign rem_dec_s  = (state_r == EMIT) && handshake_s;

  rle_repeat_counter u_repeat_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (rem_load_s),
    .load_value (cnt_r - DATA_ONE),
    .dec        (rem_dec_s),
    .last       (rem_last_s)
  );

  // Decoder FSM with the registered output slot and error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= DATA_ZERO;
      out_valid_r <= 1'b0;
      out_data_r  <= DATA_ZERO;
      err_r       <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        IDLE, HAVE_CNT: begin
          if (accept_s && in_tag) begin
            if (in_data == DATA_ZERO) begin
              err_r <= 1'b1;
            end else begin
              // A second count before any literal replaces the first one.
              err_r   <= (state_r == HAVE_CNT);
              cnt_r   <= in_data;
              state_r <= HAVE_CNT;
            end
            if (handshake_s) begin
              out_valid_r <= 1'b0;
            end
          end else if (accept_s && !lit_ok_s) begin
            err_r   <= 1'b1;
            cnt_r   <= DATA_ZERO;
            state_r <= IDLE;
            if (handshake_s) begin
              out_valid_r <= 1'b0;
            end
          end else if (accept_s) begin
            out_data_r  <= in_data;
            out_valid_r <= 1'b1;
            if (state_r == HAVE_CNT) begin
              cnt_r   <= DATA_ZERO;
              state_r <= (cnt_r > DATA_ONE) ? EMIT : IDLE;
            end else begin
              state_r <= IDLE;
            end
          end else if (handshake_s) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        EMIT: begin
          // The final copy stays presented after leaving EMIT.
          if (rem_last_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= EMIT;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign err       = err_r;

endmodule

// File: tb/tb_rle_decoder.sv
// Scoreboard bench for rle_decoder: a word-level reference model fills the
// expected queues, a negedge monitor pops and compares the DUT responses.
`timescale 1ns/1ps
module tb_rle_decoder;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic       in_tag;
  logic [6:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [6:0] out_data;
  logic       out_ready;
  logic       err;

  rle_decoder dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int err_pulses = 0;
  int ready_mode = 0;
  int m_cnt = 0;
  logic [6:0] exp_q[$];
  logic       err_q[$];
  logic       prev_acc = 1'b0;
  logic       prev_stall = 1'b0;
  logic [6:0] prev_data = 7'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one call per accepted word, from the decoding rules.
  task automatic model_word(input logic tag, input logic [6:0] d);
    int reps;
    if (tag) begin
      if (d == 7'd0) begin
        err_q.push_back(1'b1);
      end else begin
        err_q.push_back(m_cnt != 0);
        m_cnt = d;
      end
    end else if (d < 7'd32) begin
      err_q.push_back(1'b1);
      m_cnt = 0;
    end else begin
      err_q.push_back(1'b0);
      reps = (m_cnt == 0) ? 1 : m_cnt;
      for (int k = 0; k < reps; k++) exp_q.push_back(d);
      m_cnt = 0;
    end
  endtask

  task automatic send(input logic tag, input logic [6:0] d);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_tag   = tag;
    in_data  = d;
    @(negedge clock);
    while (!in_ready && g < 400) begin
      g++;
      @(negedge clock);
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    else model_word(tag, d);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts cycles with in_ready low, starting the cycle after acceptance.
  task automatic measure_low(input string name, input int exp_low);
    int n;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 400) begin
      n++;
      @(negedge clock);
    end
    check(name, n, exp_low);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 3000) begin
      @(posedge clock);
      g++;
    end
    check("drain_done", int'(g < 3000), 1);
    @(posedge clock);
    #1;
  endtask

  // Output-ready driver for the randomized phase.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: err timing, output data, and stall stability.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_acc   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_acc) begin
          if (err_q.size() == 0) check("err_q_empty", 1, 0);
          else check("err", err, err_q.pop_front());
        end else begin
          check("err_idle", err, 0);
        end
        if (err) err_pulses++;
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, prev_data);
        end
        if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready) begin
          beats++;
          if (exp_q.size() == 0) check("unexpected_beat", out_data, -1);
          else check("out_data", out_data, exp_q.pop_front());
        end
        prev_acc   = in_valid && in_ready;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int e0;
    int g;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_tag    = 1'b0;
    in_data   = 7'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single literal: one beat, next-cycle latency, in_ready stays high.
    send(1'b0, 7'h41);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 7'h41);
    check("lat_in_ready", in_ready, 1);
    drain();

    // Five-copy run with out_ready high.
    b0 = beats;
    send(1'b1, 7'd5);
    send(1'b0, 7'h42);
    measure_low("run5_low", 4);
    drain();
    check("run5_beats", beats - b0, 5);

    // Three-copy run with stalls.
    b0 = beats;
    send(1'b1, 7'd3);
    send(1'b0, 7'h43);
    out_ready = 1'b1; @(posedge clock); #1;
    out_ready = 1'b0; @(posedge clock); #1;
    out_ready = 1'b0; @(posedge clock); #1;
    out_ready = 1'b1; @(posedge clock); #1;
    out_ready = 1'b1; @(posedge clock); #1;
    drain();
    check("stall_beats", beats - b0, 3);

    // Zero count and overwritten count both flag err.
    b0 = beats;
    e0 = err_pulses;
    send(1'b1, 7'd0);
    send(1'b1, 7'd2);
    send(1'b1, 7'd4);
    send(1'b0, 7'h44);
    drain();
    check("ovw_beats", beats - b0, 4);
    check("ovw_errs", err_pulses - e0, 2);

    // Illegal literal discards the held count.
    b0 = beats;
    e0 = err_pulses;
    send(1'b1, 7'd6);
    send(1'b0, 7'h1F);
    send(1'b0, 7'h45);
    drain();
    check("ill_beats", beats - b0, 1);
    check("ill_errs", err_pulses - e0, 1);

    // Boundaries: MIN_CHAR itself, count of 1, maximum count.
    b0 = beats;
    send(1'b0, 7'd32);
    send(1'b1, 7'd1);
    send(1'b0, 7'h49);
    measure_low("cnt1_low", 0);
    send(1'b1, 7'd127);
    send(1'b0, 7'h48);
    measure_low("run127_low", 126);
    drain();
    check("bound_beats", beats - b0, 129);

    // Asynchronous reset in the middle of a ten-copy run.
    b0 = beats;
    send(1'b1, 7'd10);
    send(1'b0, 7'h46);
    g = 0;
    while ((beats - b0) < 3 && g < 100) begin
      @(posedge clock);
      g++;
    end
    check("mid_wait", int'(g < 100), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    err_q.delete();
    m_cnt = 0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    b0 = beats;
    send(1'b0, 7'h47);
    drain();
    check("post_rst_beats", beats - b0, 1);

    // Randomized traffic with random back-pressure.
    ready_mode = 1;
    for (int i = 0; i < 250; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) begin
        @(posedge clock);
        #1;
      end
      if ($urandom_range(0, 9) < 4) send(1'b1, 7'($urandom_range(0, 6)));
      else if ($urandom_range(0, 7) == 0) send(1'b0, 7'($urandom_range(0, 31)));
      else send(1'b0, 7'($urandom_range(32, 127)));
    end
    drain();
    ready_mode = 0;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("final_exp_q", exp_q.size(), 0);
    check("final_err_q", err_q.size(), 0);
    check("final_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
